// File: rtl/rectangle128_keysched_pkg.sv
// Shared constants, FSM encodings and key-state helpers for the RECTANGLE128 key schedule.
package rectangle128_keysched_pkg;

  localparam int unsigned RECT_NUM_RKEYS = 26;
  localparam int unsigned RECT_ADDR_W    = 5;
  localparam int unsigned RECT_KEY_W     = 128;
  localparam int unsigned RECT_RK_W      = 64;
  localparam int unsigned RECT_ROW_W     = 32;
  localparam int unsigned RECT_RC_W      = 5;

  localparam logic [RECT_RC_W-1:0] RECT_RC_INIT = 5'h01;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  // 128-bit key state viewed as four 32-bit rows; row0 occupies the low bits.
  typedef struct packed {
    logic [RECT_ROW_W-1:0] row3;
    logic [RECT_ROW_W-1:0] row2;
    logic [RECT_ROW_W-1:0] row1;
    logic [RECT_ROW_W-1:0] row0;
  } key_rows_t;

  function automatic logic [RECT_RC_W-1:0] rc_next(input logic [RECT_RC_W-1:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

  function automatic logic [RECT_RK_W-1:0] rk_extract(input key_rows_t k);
    return {k.row3[15:0], k.row2[15:0], k.row1[15:0], k.row0[15:0]};
  endfunction

endpackage

// File: rtl/rectangle128_sbox.sv
// RECTANGLE 4-bit S-box; bit 0 of x/y_c maps to row 0 of the key/state column.
module rectangle128_sbox (
  input  logic [3:0] x,
  output logic [3:0] y_c
);

  always_comb begin
    y_c = 4'h0;
    case (x)
      4'h0: y_c = 4'h6;
      4'h1: y_c = 4'h5;
      4'h2: y_c = 4'hC;
      4'h3: y_c = 4'hA;
      4'h4: y_c = 4'h1;
      4'h5: y_c = 4'hE;
      4'h6: y_c = 4'h7;
      4'h7: y_c = 4'h9;
      4'h8: y_c = 4'hB;
      4'h9: y_c = 4'h0;
      4'hA: y_c = 4'h3;
      4'hB: y_c = 4'hD;
      4'hC: y_c = 4'h8;
      4'hD: y_c = 4'hF;
      4'hE: y_c = 4'h4;
      4'hF: y_c = 4'h2;
      default: y_c = 4'h0;
    endcase
  end

endmodule

// File: rtl/rectangle128_keysched.sv
// RECTANGLE128 key expansion into a 26-entry round-key store with combinational read.
// Optional RECTANGLE128_KEY_ZEROIZE_EN adds a single-cycle zeroize input.
module rectangle128_keysched
  import rectangle128_keysched_pkg::*;
#(
  parameter int unsigned           NUM_RKEYS = RECT_NUM_RKEYS,
  parameter logic [RECT_RC_W-1:0]  RC_INIT   = RECT_RC_INIT
) (
  input  logic                   Clk,
  input  logic                   Rst,
`ifdef RECTANGLE128_KEY_ZEROIZE_EN
  input  logic                   zeroize,
`endif
  input  logic                   keyLoad,
  input  logic [RECT_KEY_W-1:0]  masterKey,
  input  logic [RECT_ADDR_W-1:0] RAddr,
  output logic [RECT_RK_W-1:0]   roundKey,
  output logic                   skey_ready,
  output logic                   busy
);

  logic [1:0]             state_q, state_d;
  key_rows_t              key_q, sb_rows, nx_rows;
  logic [RECT_RC_W-1:0]   rc_q;
  logic [RECT_ADDR_W-1:0] idx_q;
  logic [RECT_RK_W-1:0]   mem [NUM_RKEYS];
  logic [3:0]             sb_col [8];
  logic                   idx_last;
  logic                   zero_c;

`ifdef RECTANGLE128_KEY_ZEROIZE_EN
  assign zero_c = zeroize;
`else
  assign zero_c = 1'b0;
`endif

  assign idx_last = (idx_q == RECT_ADDR_W'(NUM_RKEYS - 1));

  // Column S-boxes on the eight low columns of the key state.
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    rectangle128_sbox u_sbox (
      .x   ({key_q.row3[j], key_q.row2[j], key_q.row1[j], key_q.row0[j]}),
      .y_c (sb_col[j])
    );
  end

  // S-box substitution, generalized Feistel row mix and round constant.
  always_comb begin
    sb_rows = key_q;
    for (int j = 0; j < 8; j++) begin
      sb_rows.row0[j] = sb_col[j][0];
      sb_rows.row1[j] = sb_col[j][1];
      sb_rows.row2[j] = sb_col[j][2];
      sb_rows.row3[j] = sb_col[j][3];
    end
    nx_rows.row0 = {sb_rows.row0[23:0], sb_rows.row0[31:24]} ^ sb_rows.row1
                   ^ RECT_ROW_W'(rc_q);
    nx_rows.row1 = sb_rows.row2;
    nx_rows.row2 = sb_rows.row3;
    nx_rows.row3 = {sb_rows.row3[15:0], sb_rows.row3[31:16]} ^ sb_rows.row0;
  end

  // Next-state logic; a load restarts expansion from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (keyLoad) state_d = EXPAND;
      EXPAND:  if (!keyLoad && idx_last) state_d = READY;
      READY:   if (keyLoad) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst || zero_c) begin
      state_q    <= IDLE;
      key_q      <= '0;
      rc_q       <= Rst ? RC_INIT : '0;
      idx_q      <= '0;
      skey_ready <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < int'(NUM_RKEYS); i++) mem[i] <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d == EXPAND);
      skey_ready <= (state_d == READY);
      if (keyLoad) begin
        key_q <= key_rows_t'(masterKey);
        rc_q  <= RC_INIT;
        idx_q <= '0;
      end else if (state_q == EXPAND) begin
        mem[idx_q] <= rk_extract(key_q);
        key_q      <= nx_rows;
        rc_q       <= rc_next(rc_q);
        idx_q      <= idx_q + RECT_ADDR_W'(1);
      end
    end
  end

  // Unmapped addresses read as zero; no bypass of same-cycle writes.
  assign roundKey = (32'(RAddr) < NUM_RKEYS) ? mem[RAddr] : '0;

endmodule

// File: tb/tb_rectangle128_keysched.sv
// Scoreboard bench for rectangle128_keysched against a row-arithmetic key schedule model.
// Define RECTANGLE128_KEY_ZEROIZE_EN to also exercise the zeroize input.
module tb_rectangle128_keysched;

  typedef logic [25:0][63:0] rk_set_t;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         keyLoad = 1'b0;
  logic [127:0] masterKey = '0;
  logic [4:0]   RAddr = '0;
  logic [63:0]  roundKey;
  logic         skey_ready;
  logic         busy;
`ifdef RECTANGLE128_KEY_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int      checks = 0;
  int      errors = 0;
  int      sweep_reqs = 0;
  int      sweeps_done = 0;
  int      pushed = 0;
  rk_set_t exp_q[$];

  rectangle128_keysched dut (
    .Clk        (Clk),
    .Rst        (Rst),
`ifdef RECTANGLE128_KEY_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .keyLoad    (keyLoad),
    .masterKey  (masterKey),
    .RAddr      (RAddr),
    .roundKey   (roundKey),
    .skey_ready (skey_ready),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  function automatic int unsigned rotl(input int unsigned x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference: apply the cipher's key update rules on four 32-bit words.
  function automatic rk_set_t model(input logic [127:0] mk);
    int unsigned sbox [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};
    int unsigned row [4];
    int unsigned t0, t3, col, s, rc;
    rk_set_t rk;
    for (int i = 0; i < 4; i++) row[i] = mk[32*i +: 32];
    rc = 1;
    for (int r = 0; r < 26; r++) begin
      rk[r] = {row[3][15:0], row[2][15:0], row[1][15:0], row[0][15:0]};
      for (int j = 0; j < 8; j++) begin
        col = 0;
        for (int i = 0; i < 4; i++) col = col | (((row[i] >> j) & 1) << i);
        s = sbox[col];
        for (int i = 0; i < 4; i++)
          row[i] = (row[i] & ~(32'd1 << j)) | (((s >> i) & 1) << j);
      end
      t0 = rotl(row[0], 8) ^ row[1] ^ rc;
      t3 = rotl(row[3], 16) ^ row[0];
      row[1] = row[2];
      row[2] = row[3];
      row[0] = t0;
      row[3] = t3;
      rc = ((rc << 1) & 32'h1E) | (((rc >> 4) ^ (rc >> 2)) & 1);
    end
    return rk;
  endfunction

  // Monitor: sweep all 32 addresses whenever skey_ready rises or a sweep is requested.
  initial begin
    logic    rdy_prev = 1'b0;
    rk_set_t e;
    logic [63:0] want;
    forever begin
      @(negedge Clk);
      if ((skey_ready && !rdy_prev) || (sweep_reqs > sweeps_done)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output skey_ready=%0b with empty scoreboard", skey_ready);
        end else begin
          e = exp_q.pop_front();
          for (int a = 0; a < 32; a++) begin
            RAddr = 5'(a);
            #1;
            want = 64'h0;
            if (a < 26) want = e[a];
            checks++;
            if (roundKey !== want) begin
              errors++;
              $display("FAIL rk[%0d] got %h expected %h", a, roundKey, want);
            end
          end
        end
        if (sweep_reqs > sweeps_done) sweeps_done++;
        else sweeps_done = sweeps_done + 0;
        rdy_prev = 1'b1;
      end else begin
        rdy_prev = skey_ready;
      end
    end
  end

  int rising_seen = 0;
  always @(negedge Clk) if (skey_ready) rising_seen <= rising_seen;

  task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Wait until the monitor has consumed every pushed expectation.
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge Clk);
      n++;
    end
    repeat (5) @(posedge Clk);
    expect_eq("scoreboard_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Pulse keyLoad with k, push its expansion, and check busy/skey_ready timing.
  task automatic do_load(input logic [127:0] k);
    int n = 0;
    int busy_cnt = 0;
    @(negedge Clk);
    masterKey = k;
    keyLoad   = 1'b1;
    exp_q.push_back(model(k));
    pushed++;
    @(posedge Clk);
    #1 keyLoad = 1'b0;
    while (!skey_ready && n < 60) begin
      if (busy) busy_cnt++;
      @(posedge Clk);
      #1;
      n++;
    end
    expect_eq("ready_latency", 64'(n), 64'd26);
    expect_eq("busy_cycles", 64'(busy_cnt), 64'd26);
    expect_eq("busy_after_ready", 64'(busy), 64'd0);
    wait_drain();
  endtask

  initial begin
    logic [127:0] k;
    rk_set_t zero_set = '0;

    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    expect_eq("reset_ready", 64'(skey_ready), 64'd0);
    expect_eq("reset_busy", 64'(busy), 64'd0);
    exp_q.push_back(zero_set);
    sweep_reqs++;
    wait_drain();

    do_load(128'h0);

    // Reload mid-expansion: only key B's table is expected.
    @(negedge Clk);
    masterKey = {$urandom, $urandom, $urandom, $urandom};
    keyLoad = 1'b1;
    @(posedge Clk);
    #1 keyLoad = 1'b0;
    repeat (9) @(posedge Clk);
    do_load({$urandom, $urandom, $urandom, $urandom});

    for (int t = 0; t < 100; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      do_load(k);
    end

    // Reset and load in the same cycle: reset wins.
    @(negedge Clk);
    Rst = 1'b1;
    keyLoad = 1'b1;
    masterKey = {$urandom, $urandom, $urandom, $urandom};
    @(posedge Clk);
    #1 Rst = 1'b0;
    keyLoad = 1'b0;
    expect_eq("rst_vs_load_ready", 64'(skey_ready), 64'd0);
    expect_eq("rst_vs_load_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge Clk);
    #1 expect_eq("rst_vs_load_idle_busy", 64'(busy), 64'd0);
    exp_q.push_back(zero_set);
    sweep_reqs++;
    wait_drain();

`ifdef RECTANGLE128_KEY_ZEROIZE_EN
    do_load({$urandom, $urandom, $urandom, $urandom});
    @(negedge Clk);
    zeroize = 1'b1;
    keyLoad = 1'b1;
    @(posedge Clk);
    #1 zeroize = 1'b0;
    keyLoad = 1'b0;
    expect_eq("zeroize_ready", 64'(skey_ready), 64'd0);
    expect_eq("zeroize_busy", 64'(busy), 64'd0);
    exp_q.push_back(zero_set);
    sweep_reqs++;
    wait_drain();
    do_load({$urandom, $urandom, $urandom, $urandom});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout pushed=%0d remaining=%0d", pushed, exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
